// File: rtl/ram_wide_port_arbiter_pkg.sv
// Shared types and helpers for the wide-port scratchpad arbiter.
package ram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_DEF);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Elements moved by one wide-port access.
    function automatic int bytes_per_access(input int data_width, input int data_size);
        return data_width / data_size;
    endfunction

    // True when [a, a+len) and [b, b+len) share at least one element.
    // Operands are 64 bits wide so address + len never wraps.
    function automatic logic overlap(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] len);
        return (a < b + len) && (b < a + len);
    endfunction

endpackage

// File: rtl/ram_wide_port_arbiter_if.sv
// Requester-side bundle of the wide-port arbiter: write, read and response channels.
interface ram_wide_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic [NUM_REQ-1:0]                 wr_valid_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_addr_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data_i;
    logic [NUM_REQ-1:0]                 wr_ready_o;
    logic [NUM_REQ-1:0]                 rd_valid_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_addr_i;
    logic [NUM_REQ-1:0]                 rd_ready_o;
    logic [NUM_REQ-1:0]                 rsp_valid_o;
    logic [DATA_WIDTH-1:0]              rsp_data_o;
    logic                               rsp_err_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
        input  wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
        output wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/ram_wide_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past each grant.
// The candidate is exposed before the stall so the caller can hazard-check it.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               stall_i,
    output logic               cand_valid_o,
    output logic [ID_W-1:0]    cand_id_o,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        cand_valid_o = 1'b0;
        cand_id_o    = '0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!cand_valid_o && valid_i[idx]) begin
                cand_valid_o = 1'b1;
                cand_id_o    = idx;
            end
        end
    end

    assign grant_o = (cand_valid_o && !stall_i) ? (NUM_REQ'(1) << cand_id_o) : '0;

    // Advance past the winner; hold when nothing was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (cand_valid_o && !stall_i) begin
            ptr_d = (cand_id_o == ID_W'(NUM_REQ - 1)) ? '0 : cand_id_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_wide_port_arbiter.sv
// Shares the wide write and read ports of the 2W2R scratchpad among NUM_REQ requesters.
// Out-of-range requests are accepted but never reach the RAM; they raise err_o instead.
module ram_wide_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int DATA_SIZE  = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       nrst,
    ram_wide_port_arbiter_if.slave     bus,
    output logic                       err_o,
    output logic [$clog2(NUM_REQ)-1:0] err_id_o,
    output logic                       ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]      ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]      ram_wr_data_o,
    output logic                       ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]      ram_rd_data_i
);

    localparam int BYTES = bytes_per_access(DATA_WIDTH, DATA_SIZE);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                  wr_any, rd_cand_valid, rd_any, rd_stall;
    logic [ID_W-1:0]       wr_id, rd_id;
    logic [NUM_REQ-1:0]    wr_grant, rd_grant;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  wr_legal, rd_legal;

    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  wr_err_q, wr_err_d;
    logic [ID_W-1:0]       wr_err_id_q, wr_err_id_d;
    logic                  rd_hold_q, rd_hold_d;
    logic [ID_W-1:0]       rd_hold_id_q, rd_hold_id_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk          (clk),
        .nrst         (nrst),
        .valid_i      (bus.wr_valid_i),
        .stall_i      (1'b0),
        .cand_valid_o (wr_any),
        .cand_id_o    (wr_id),
        .grant_o      (wr_grant)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk          (clk),
        .nrst         (nrst),
        .valid_i      (bus.rd_valid_i),
        .stall_i      (rd_stall),
        .cand_valid_o (rd_cand_valid),
        .cand_id_o    (rd_id),
        .grant_o      (rd_grant)
    );

    assign wr_addr  = bus.wr_addr_i[wr_id];
    assign rd_addr  = bus.rd_addr_i[rd_id];
    assign wr_legal = ({1'b0, wr_addr} + BYTES_C) <= DEPTH_C;
    assign rd_legal = ({1'b0, rd_addr} + BYTES_C) <= DEPTH_C;

    // A read overlapping the granted write waits one cycle so it observes the new data.
    assign rd_stall = wr_any && rd_cand_valid &&
                      overlap(64'(wr_addr), 64'(rd_addr), 64'(BYTES));
    assign rd_any   = |rd_grant;

    assign bus.wr_ready_o = wr_grant;
    assign bus.rd_ready_o = rd_grant;

    assign ram_wr_en_o   = wr_any && wr_legal;
    assign ram_wr_addr_o = ram_wr_en_o ? wr_addr : '0;
    assign ram_wr_data_o = ram_wr_en_o ? bus.wr_data_i[wr_id] : '0;
    assign ram_rd_en_o   = rd_any && rd_legal;
    assign ram_rd_addr_o = ram_rd_en_o ? rd_addr : '0;

    assign rsp_vld_d   = rd_grant;
    assign rsp_err_d   = rd_any && !rd_legal;
    assign rsp_id_d    = rd_id;
    assign wr_err_d    = wr_any && !wr_legal;
    assign wr_err_id_d = wr_id;

    // Write errors report first; a read error that collides is parked for the next cycle.
    // If a parked error is still waiting when another collision occurs, the newer one wins.
    always_comb begin
        rd_hold_d    = rd_hold_q;
        rd_hold_id_d = rd_hold_id_q;
        if (wr_err_q) begin
            if (rsp_err_q) begin
                rd_hold_d    = 1'b1;
                rd_hold_id_d = rsp_id_q;
            end
        end else if (rd_hold_q) begin
            rd_hold_d    = rsp_err_q;
            rd_hold_id_d = rsp_id_q;
        end
    end

    // Response and error pipeline registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_vld_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= '0;
            wr_err_q     <= 1'b0;
            wr_err_id_q  <= '0;
            rd_hold_q    <= 1'b0;
            rd_hold_id_q <= '0;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
            wr_err_q     <= wr_err_d;
            wr_err_id_q  <= wr_err_id_d;
            rd_hold_q    <= rd_hold_d;
            rd_hold_id_q <= rd_hold_id_d;
        end
    end

    assign bus.rsp_valid_o = rsp_vld_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_data_o  = (|rsp_vld_q && !rsp_err_q) ? ram_rd_data_i : '0;

    assign err_o    = wr_err_q || rd_hold_q || rsp_err_q;
    assign err_id_o = wr_err_q  ? wr_err_id_q  :
                      rd_hold_q ? rd_hold_id_q :
                      rsp_err_q ? rsp_id_q     : '0;

endmodule

// File: tb/tb_ram_wide_port_arbiter.sv
// Bench for ram_wide_port_arbiter: directed cases then random traffic against a
// request-level reference model; responses and errors are checked by a scoreboard monitor.
module tb_ram_wide_port_arbiter;
    import ram_arb_pkg::*;

    localparam int NR    = 4;
    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int DS    = 8;
    localparam int DEPTH = 1024;
    localparam int BY    = DW / DS;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ram_wide_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          err_o;
    req_id_t       err_id_o;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;

    ram_wide_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_SIZE(DS), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .bus           (bus),
        .err_o         (err_o),
        .err_id_o      (err_id_o),
        .ram_wr_en_o   (ram_wr_en),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_rd_en_o   (ram_rd_en),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data)
    );

    // Scratchpad RAM seen by the DUT: 1-cycle read latency, output held otherwise.
    logic [7:0] ram_env [DEPTH];
    always @(posedge clk) begin
        if (ram_rd_en) for (int j = 0; j < BY; j++) ram_rd_data[j*8 +: 8] <= ram_env[ram_rd_addr + j];
        if (ram_wr_en) for (int j = 0; j < BY; j++) ram_env[ram_wr_addr + j] <= ram_wr_data[j*8 +: 8];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: requester intents, RR pointers, memory contents.
    bit            wv [NR];
    logic [AW-1:0] wa [NR];
    logic [DW-1:0] wd [NR];
    bit            rv [NR];
    logic [AW-1:0] ra [NR];
    int            wwait [NR];
    int            wptr, rptr;
    logic [7:0]    mem_m [DEPTH];

    typedef struct { int due; int id; bit err; logic [DW-1:0] data; } rsp_t;
    typedef struct { int due; int id; } err_t;
    rsp_t rsp_q [$];
    err_t err_q [$];
    bit   mon_en = 1'b0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int j = 0; j < BY; j++) r[j*8 +: 8] = mem_m[a + j];
        return r;
    endfunction

    // Monitor: every cycle the response and error outputs must match the scoreboard head.
    rsp_t          m_rsp;
    err_t          m_err;
    logic [NR-1:0] m_oh;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                m_rsp = rsp_q.pop_front();
                m_oh  = NR'(1) << m_rsp.id;
                chk("rsp_valid", bus.rsp_valid_o, m_oh);
                chk("rsp_err", bus.rsp_err_o, m_rsp.err);
                chk("rsp_data", bus.rsp_data_o, m_rsp.data);
            end else begin
                chk("rsp_idle", bus.rsp_valid_o, '0);
            end
            if (err_q.size() > 0 && err_q[0].due == cyc) begin
                m_err = err_q.pop_front();
                chk("err_o", err_o, 1'b1);
                chk("err_id", err_id_o, m_err.id);
            end else begin
                chk("err_idle", err_o, 1'b0);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.wr_valid_i[i] = wv[i];
            bus.wr_addr_i[i]  = wa[i];
            bus.wr_data_i[i]  = wd[i];
            bus.rd_valid_i[i] = rv[i];
            bus.rd_addr_i[i]  = ra[i];
        end
    endtask

    // One clock cycle: drive intents, predict grants, check the cycle, retire accepted requests.
    task automatic step();
        int wg, rc, rg;
        bit wl, rl, stall;
        longint aw, ar;
        logic [NR-1:0] ewr, erd;
        rsp_t r;
        err_t e;
        drive();
        wg = -1; rc = -1; wl = 0; rl = 0; aw = 0; ar = 0;
        for (int k = 0; k < NR; k++) begin
            if (wg < 0 && wv[(wptr + k) % NR]) wg = (wptr + k) % NR;
            if (rc < 0 && rv[(rptr + k) % NR]) rc = (rptr + k) % NR;
        end
        if (wg >= 0) begin aw = longint'({32'd0, wa[wg]}); wl = (aw + BY <= DEPTH); end
        if (rc >= 0) begin ar = longint'({32'd0, ra[rc]}); rl = (ar + BY <= DEPTH); end
        stall = (wg >= 0) && (rc >= 0) && (ar < aw + BY) && (aw < ar + BY);
        rg  = stall ? -1 : rc;
        ewr = (wg >= 0) ? (NR'(1) << wg) : '0;
        erd = (rg >= 0) ? (NR'(1) << rg) : '0;
        if (wg >= 0 && !wl) begin e.due = cyc + 1; e.id = wg; err_q.push_back(e); end
        if (rg >= 0) begin
            r.due = cyc + 1; r.id = rg; r.err = !rl;
            r.data = rl ? mem_rd(ra[rg]) : '0;
            rsp_q.push_back(r);
            if (!rl) begin
                e.due = (wg >= 0 && !wl) ? cyc + 2 : cyc + 1; e.id = rg;
                err_q.push_back(e);
            end
        end
        if (wg >= 0 && wl) for (int j = 0; j < BY; j++) mem_m[wa[wg] + j] = wd[wg][j*8 +: 8];
        @(negedge clk);
        chk("wr_ready", bus.wr_ready_o, ewr);
        chk("rd_ready", bus.rd_ready_o, erd);
        chk("ram_wr_en", ram_wr_en, (wg >= 0) && wl);
        chk("ram_rd_en", ram_rd_en, (rg >= 0) && rl);
        if (wg >= 0 && wl) begin
            chk("ram_wr_addr", ram_wr_addr, wa[wg]);
            chk("ram_wr_data", ram_wr_data, wd[wg]);
        end
        if (rg >= 0 && rl) chk("ram_rd_addr", ram_rd_addr, ra[rg]);
        for (int i = 0; i < NR; i++) begin
            if (wv[i]) begin
                if (bus.wr_ready_o[i]) begin
                    chk("wr_wait_bound", wwait[i] <= NR - 1, 1'b1);
                    wwait[i] = 0;
                end else begin
                    wwait[i]++;
                end
            end
        end
        if (wg >= 0) begin wv[wg] = 0; wptr = (wg + 1) % NR; end
        if (rg >= 0) begin rv[rg] = 0; rptr = (rg + 1) % NR; end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ram_env[i] = '0; mem_m[i] = '0; end
        for (int i = 0; i < NR; i++) begin
            wv[i] = 0; rv[i] = 0; wa[i] = '0; ra[i] = '0; wd[i] = '0; wwait[i] = 0;
        end
        wptr = 0; rptr = 0;
        drive();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", bus.wr_ready_o, '0);
        chk("rst_rd_ready", bus.rd_ready_o, '0);
        chk("rst_rsp_valid", bus.rsp_valid_o, '0);
        chk("rst_rsp_err", bus.rsp_err_o, 1'b0);
        chk("rst_rsp_data", bus.rsp_data_o, '0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_ram_wr_en", ram_wr_en, 1'b0);
        chk("rst_ram_rd_en", ram_rd_en, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        mon_en = 1'b1;

        // Single write then read-back on requester 0.
        wv[0] = 1; wa[0] = 32'h10; wd[0] = {32{8'hA5}};
        step();
        rv[0] = 1; ra[0] = 32'h10;
        step();
        step();

        // All four readers held: round-robin rotation with back-to-back responses.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NR; i++) if (!rv[i]) begin rv[i] = 1; ra[i] = AW'(i * 64); end
            step();
        end
        for (int i = 0; i < NR; i++) rv[i] = 0;
        step();

        // Overlapping write/read stalls the read; adjacent ranges do not.
        wv[2] = 1; wa[2] = 32'h40; wd[2] = {8{$urandom}};
        rv[1] = 1; ra[1] = 32'h50;
        step();
        step();
        wv[2] = 1; wa[2] = 32'h40; wd[2] = {8{$urandom}};
        rv[1] = 1; ra[1] = 32'h60;
        step();
        step();

        // Bounds: first illegal address, last legal one, a wrapping one, and write+read both illegal.
        rv[3] = 1; ra[3] = AW'(DEPTH - BY + 1);
        step();
        rv[3] = 1; ra[3] = AW'(DEPTH - BY);
        step();
        rv[0] = 1; ra[0] = 32'hFFFF_FFF0;
        step();
        wv[1] = 1; wa[1] = 32'd1000; wd[1] = {8{$urandom}};
        rv[2] = 1; ra[2] = 32'd2000;
        step();
        repeat (3) step();

        // Reset right after a granted read: response dropped, pointers restart.
        rv[2] = 1; ra[2] = 32'h100;
        step();
        rsp_q.delete();
        err_q.delete();
        nrst = 1'b0;
        for (int i = 0; i < NR; i++) begin wv[i] = 0; rv[i] = 0; wwait[i] = 0; end
        drive();
        #1;
        chk("rsp_valid_in_reset", bus.rsp_valid_o, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        wptr = 0; rptr = 0;
        for (int i = 0; i < NR; i++) begin rv[i] = 1; ra[i] = AW'(i * 32); end
        step();
        for (int i = 0; i < NR; i++) rv[i] = 0;
        step();

        // Random traffic: legal writes, mostly legal reads.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!wv[i] && $urandom_range(0, 2) == 0) begin
                    wv[i] = 1;
                    wa[i] = AW'($urandom_range(0, DEPTH - BY));
                    wd[i] = {8{$urandom}};
                end
                if (!rv[i] && $urandom_range(0, 1) == 0) begin
                    rv[i] = 1;
                    ra[i] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH - BY + 1, DEPTH))
                                                         : AW'($urandom_range(0, DEPTH - BY));
                end
            end
            step();
        end

        // Drain outstanding requests, then everything must have been seen.
        for (int n = 0; n < 2 * NR + 4; n++) begin
            if (n == 0) for (int i = 0; i < NR; i++) begin wv[i] = wv[i]; rv[i] = rv[i]; end
            step();
        end
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
